// File: rtl/tube_r3_dma.sv
// Purpose : parasite-side DMA engine moving bytes between Tube register 3 and parasite memory on PNMI.
// Latency : first Tube access 1 cycle after nmi_req is seen in ARMED; memory phase waits for mem_ack.
// Backpressure: mem_ack stalls MEM_WR/MEM_RD indefinitely; the CPU is held via cpu_hold while a byte moves.
//
// Ports:
//   p_phi2, p_rst_b            clock (rising edge) / async active-low reset
//   cfg_start, cfg_stop        one-cycle control pulses (stop wins over start)
//   cfg_dir, cfg_two_byte,
//   cfg_addr                   transfer setup, latched on cfg_start
//   p_nmi_b                    Tube PNMI, active low, asynchronous
//   tube_*                     Tube register interface (cs_b active low, rdnw 1 = read)
//   mem_*                      parasite memory request interface (ack completes request)
//   cpu_hold, busy, cur_addr   status
// Optional feature macro TUBE_R3_DMA_COUNT_EN adds cfg_count (byte budget, 0 = unlimited)
// and a one-cycle done pulse when the budget is exhausted.
module tube_r3_dma #(
    parameter int          ADDR_W       = 16,
    parameter int          NMI_HOLDOFF  = 3,
    parameter logic [2:0]  TUBE_R3_ADDR = 3'h5
) (
    input  logic              p_phi2,
    input  logic              p_rst_b,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_dir,
    input  logic              cfg_two_byte,
    input  logic [ADDR_W-1:0] cfg_addr,
`ifdef TUBE_R3_DMA_COUNT_EN
    input  logic [15:0]       cfg_count,
    output logic              done,
`endif
    input  logic              p_nmi_b,
    output logic              tube_cs_b,
    output logic [2:0]        tube_addr,
    output logic              tube_rdnw,
    input  logic [7:0]        tube_din,
    output logic [7:0]        tube_dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int HO_W = (NMI_HOLDOFF < 2) ? 1 : $clog2(NMI_HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_TUBE_RD = 3'd2,
        S_MEM_WR  = 3'd3,
        S_MEM_RD  = 3'd4,
        S_TUBE_WR = 3'd5,
        S_NEXT    = 3'd6
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                dir_q,      dir_d;
    logic                two_byte_q, two_byte_d;
    logic                idx_q,      idx_d;
    logic [7:0]          data_q,     data_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic [HO_W-1:0]     holdoff_q,  holdoff_d;
    logic                nmi_meta_q, nmi_sync_q;
    logic                nmi_req;
    logic                tube_access;
`ifdef TUBE_R3_DMA_COUNT_EN
    logic [15:0]         cnt_q,      cnt_d;
    logic                cnt_lim_q,  cnt_lim_d;
    logic                done_q,     done_d;
`endif

    // Two-flop synchroniser for the asynchronous PNMI; resets inactive (high).
    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            nmi_meta_q <= 1'b1;
            nmi_sync_q <= 1'b1;
        end else begin
            nmi_meta_q <= p_nmi_b;
            nmi_sync_q <= nmi_meta_q;
        end
    end

    // The Tube needs time to withdraw PNMI after it has been serviced, so
    // the request is masked for NMI_HOLDOFF cycles after every Tube access.
    assign tube_access = (state_q == S_TUBE_RD) || (state_q == S_TUBE_WR);
    assign nmi_req     = !nmi_sync_q && (holdoff_q == '0);

    always_comb begin
        holdoff_d = holdoff_q;
        if (tube_access) begin
            holdoff_d = HO_W'(NMI_HOLDOFF);
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        dir_d      = dir_q;
        two_byte_d = two_byte_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cpu_hold_d = cpu_hold_q;
`ifdef TUBE_R3_DMA_COUNT_EN
        cnt_d      = cnt_q;
        cnt_lim_d  = cnt_lim_q;
        done_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cpu_hold_d = 1'b0;
                if (cfg_start) begin
                    cur_addr_d = cfg_addr;
                    dir_d      = cfg_dir;
                    two_byte_d = cfg_two_byte;
                    idx_d      = 1'b0;
`ifdef TUBE_R3_DMA_COUNT_EN
                    cnt_d      = cfg_count;
                    cnt_lim_d  = (cfg_count != 16'd0);
`endif
                    state_d    = S_ARMED;
                end
            end

            S_ARMED: begin
                cpu_hold_d = 1'b0;
                if (nmi_req) begin
                    cpu_hold_d = 1'b1;
                    state_d    = dir_q ? S_MEM_RD : S_TUBE_RD;
                end
            end

            S_TUBE_RD: begin
                data_d  = tube_din;
                state_d = S_MEM_WR;
            end

            S_MEM_WR: begin
                if (mem_ack) begin
                    state_d = S_NEXT;
                end
            end

            S_MEM_RD: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = S_TUBE_WR;
                end
            end

            S_TUBE_WR: begin
                state_d = S_NEXT;
            end

            S_NEXT: begin
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                if (two_byte_q && !idx_q) begin
                    // Second byte of a V-flag pair: the Tube raised only one
                    // PNMI for both, so go straight on without re-arming.
                    idx_d   = 1'b1;
                    state_d = dir_q ? S_MEM_RD : S_TUBE_RD;
                end else begin
                    idx_d      = 1'b0;
                    cpu_hold_d = 1'b0;
                    state_d    = S_ARMED;
                end
`ifdef TUBE_R3_DMA_COUNT_EN
                cnt_d = cnt_q - 16'd1;
                // Budget exhausted takes priority, even mid-pair.
                if (cnt_lim_q && (cnt_q == 16'd1)) begin
                    idx_d      = 1'b0;
                    cpu_hold_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
`endif
            end

            default: begin
                cpu_hold_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Stop overrides everything, including a same-cycle start and any
        // memory access still waiting for its ack.
        if (cfg_stop) begin
            state_d    = S_IDLE;
            cpu_hold_d = 1'b0;
            idx_d      = 1'b0;
`ifdef TUBE_R3_DMA_COUNT_EN
            done_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            dir_q      <= 1'b0;
            two_byte_q <= 1'b0;
            idx_q      <= 1'b0;
            data_q     <= 8'h00;
            cpu_hold_q <= 1'b0;
            holdoff_q  <= '0;
`ifdef TUBE_R3_DMA_COUNT_EN
            cnt_q      <= 16'd0;
            cnt_lim_q  <= 1'b0;
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            dir_q      <= dir_d;
            two_byte_q <= two_byte_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            cpu_hold_q <= cpu_hold_d;
            holdoff_q  <= holdoff_d;
`ifdef TUBE_R3_DMA_COUNT_EN
            cnt_q      <= cnt_d;
            cnt_lim_q  <= cnt_lim_d;
            done_q     <= done_d;
`endif
        end
    end

    // Bus outputs decode directly from state so an async reset clears
    // them at once and idle values are always zero.
    always_comb begin
        tube_cs_b = 1'b1;
        tube_addr = 3'h0;
        tube_rdnw = 1'b1;
        tube_dout = 8'h00;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (state_q)
            S_TUBE_RD: begin
                tube_cs_b = 1'b0;
                tube_addr = TUBE_R3_ADDR;
            end
            S_TUBE_WR: begin
                tube_cs_b = 1'b0;
                tube_addr = TUBE_R3_ADDR;
                tube_rdnw = 1'b0;
                tube_dout = data_q;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_addr_q;
                mem_wdata = data_q;
            end
            S_MEM_RD: begin
                mem_req   = 1'b1;
                mem_addr  = cur_addr_q;
            end
            default: ;
        endcase
    end

    assign cpu_hold = cpu_hold_q;
    assign busy     = (state_q != S_IDLE);
    assign cur_addr = cur_addr_q;
`ifdef TUBE_R3_DMA_COUNT_EN
    assign done     = done_q;
`endif

endmodule

// File: tb/tb_tube_r3_dma.sv
// Purpose : directed self-checking bench for tube_r3_dma.
// Latency : inputs driven 1 time unit after the rising edge, outputs checked there too.
// Backpressure: mem_ack is driven directly by the sequence to stall or complete accesses.
module tb_tube_r3_dma;

    logic        p_phi2;
    logic        p_rst_b;
    logic        cfg_start, cfg_stop, cfg_dir, cfg_two_byte;
    logic [15:0] cfg_addr;
    logic        p_nmi_b;
    logic        tube_cs_b;
    logic [2:0]  tube_addr;
    logic        tube_rdnw;
    logic [7:0]  tube_din;
    logic [7:0]  tube_dout;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        cpu_hold, busy;
    logic [15:0] cur_addr;
`ifdef TUBE_R3_DMA_COUNT_EN
    logic [15:0] cfg_count;
    logic        done;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Activity logs filled by the monitor.
    int          tube_rd_n = 0;
    logic [7:0]  tube_wr_q[$];
    logic [15:0] mem_wa_q[$];
    logic [7:0]  mem_wd_q[$];
    int          tube_t_q[$];
    int          done_n = 0;

    tube_r3_dma #(.ADDR_W(16), .NMI_HOLDOFF(3), .TUBE_R3_ADDR(3'h5)) dut (
        .p_phi2       (p_phi2),
        .p_rst_b      (p_rst_b),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_dir      (cfg_dir),
        .cfg_two_byte (cfg_two_byte),
        .cfg_addr     (cfg_addr),
`ifdef TUBE_R3_DMA_COUNT_EN
        .cfg_count    (cfg_count),
        .done         (done),
`endif
        .p_nmi_b      (p_nmi_b),
        .tube_cs_b    (tube_cs_b),
        .tube_addr    (tube_addr),
        .tube_rdnw    (tube_rdnw),
        .tube_din     (tube_din),
        .tube_dout    (tube_dout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .cur_addr     (cur_addr)
    );

    initial p_phi2 = 1'b0;
    always #5 p_phi2 = ~p_phi2;

    // Memory contents seen by the engine.
    assign mem_rdata = (mem_addr == 16'h2000) ? 8'h11 :
                       (mem_addr == 16'h2001) ? 8'h22 : 8'h00;

    always @(posedge p_phi2) begin
        cyc = cyc + 1;
        if (p_rst_b) begin
            if (!tube_cs_b) begin
                tube_t_q.push_back(cyc);
                if (tube_rdnw) tube_rd_n = tube_rd_n + 1;
                else           tube_wr_q.push_back(tube_dout);
            end
            if (mem_req && mem_we && mem_ack) begin
                mem_wa_q.push_back(mem_addr);
                mem_wd_q.push_back(mem_wdata);
            end
`ifdef TUBE_R3_DMA_COUNT_EN
            if (done) done_n = done_n + 1;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge p_phi2);
            #1;
        end
    endtask

    task automatic clear_logs();
        tube_rd_n = 0;
        done_n    = 0;
        tube_wr_q.delete();
        mem_wa_q.delete();
        mem_wd_q.delete();
        tube_t_q.delete();
    endtask

    task automatic start(input logic [15:0] a, input logic d, input logic tb);
        cfg_addr = a; cfg_dir = d; cfg_two_byte = tb; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic stop();
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
    endtask

    // Wait (bounded) for a Tube chip select; a timeout is reported by the check.
    task automatic wait_tube(input string tag);
        for (int i = 0; i < 30 && tube_cs_b; i++) tick(1);
        check(tag, tube_cs_b, 1'b0);
    endtask

    initial begin
        p_rst_b = 1'b0; cfg_start = 0; cfg_stop = 0; cfg_dir = 0; cfg_two_byte = 0;
        cfg_addr = 16'h0; p_nmi_b = 1'b1; tube_din = 8'h00; mem_ack = 1'b0;
`ifdef TUBE_R3_DMA_COUNT_EN
        cfg_count = 16'd0;
`endif
        tick(2);
        // Reset state
        check("rst_tube_cs_b", tube_cs_b, 1'b1);
        check("rst_tube_rdnw", tube_rdnw, 1'b1);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_cpu_hold",  cpu_hold,  1'b0);
        check("rst_cur_addr",  cur_addr,  16'h0000);
        p_rst_b = 1'b1;
        tick(1);

        // 1: single byte Tube -> memory
        start(16'h0400, 1'b0, 1'b0);
        check("t1_busy_armed", busy, 1'b1);
        check("t1_cur_addr_armed", cur_addr, 16'h0400);
        clear_logs();
        tube_din = 8'hA5; mem_ack = 1'b1; p_nmi_b = 1'b0;
        wait_tube("t1_tube_seen");
        p_nmi_b = 1'b0;
        check("t1_tube_addr", tube_addr, 3'h5);
        check("t1_tube_rdnw", tube_rdnw, 1'b1);
        check("t1_cpu_hold_active", cpu_hold, 1'b1);
        p_nmi_b = 1'b1;
        tick(10);
        check("t1_tube_reads", tube_rd_n, 1);
        check("t1_mem_writes", mem_wa_q.size(), 1);
        check("t1_mem_wa", mem_wa_q[0], 16'h0400);
        check("t1_mem_wd", mem_wd_q[0], 8'hA5);
        check("t1_cur_addr", cur_addr, 16'h0401);
        check("t1_cpu_hold", cpu_hold, 1'b0);
        check("t1_busy", busy, 1'b1);

        // 2: two-byte memory -> Tube on one PNMI
        stop();
        check("t2_stop_idle", busy, 1'b0);
        start(16'h2000, 1'b1, 1'b1);
        clear_logs();
        p_nmi_b = 1'b0;
        wait_tube("t2_tube_seen");
        check("t2_first_dout", tube_dout, 8'h11);
        check("t2_first_rdnw", tube_rdnw, 1'b0);
        p_nmi_b = 1'b1;
        tick(15);
        check("t2_tube_writes", tube_wr_q.size(), 2);
        check("t2_wr0", tube_wr_q[0], 8'h11);
        check("t2_wr1", tube_wr_q[1], 8'h22);
        check("t2_cur_addr", cur_addr, 16'h2002);
        check("t2_no_reads", tube_rd_n, 0);

        // 3: PNMI held low continuously, accesses spaced by the holdoff
        stop();
        start(16'h3000, 1'b0, 1'b0);
        clear_logs();
        tube_din = 8'h5A;
        p_nmi_b = 1'b0;
        for (int i = 0; i < 60 && tube_t_q.size() < 3; i++) tick(1);
        p_nmi_b = 1'b1;
        check("t3_three_access", tube_t_q.size() >= 3, 1'b1);
        check("t3_gap0", (tube_t_q[1] - tube_t_q[0]) >= 3, 1'b1);
        check("t3_gap1", (tube_t_q[2] - tube_t_q[1]) >= 3, 1'b1);
        check("t3_wa0", mem_wa_q[0], 16'h3000);
        check("t3_wa1", mem_wa_q[1], 16'h3001);
        tick(10);
        stop();

        // 4: address wrap FFFF -> 0000
        start(16'hFFFF, 1'b0, 1'b0);
        clear_logs();
        tube_din = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            p_nmi_b = 1'b0;
            wait_tube("t4_tube_seen");
            p_nmi_b = 1'b1;
            tick(8);
        end
        check("t4_mem_writes", mem_wa_q.size(), 2);
        check("t4_wa0", mem_wa_q[0], 16'hFFFF);
        check("t4_wa1", mem_wa_q[1], 16'h0000);
        check("t4_cur_addr", cur_addr, 16'h0001);
        stop();

        // 5: stop while MEM_RD is stalled
        mem_ack = 1'b0;
        start(16'h2000, 1'b1, 1'b0);
        clear_logs();
        p_nmi_b = 1'b0;
        for (int i = 0; i < 30 && !mem_req; i++) tick(1);
        check("t5_mem_req", mem_req, 1'b1);
        check("t5_mem_we", mem_we, 1'b0);
        check("t5_mem_addr", mem_addr, 16'h2000);
        p_nmi_b = 1'b1;
        tick(3);
        check("t5_still_waiting", mem_req, 1'b1);
        stop();
        check("t5_mem_req_off", mem_req, 1'b0);
        check("t5_cpu_hold_off", cpu_hold, 1'b0);
        check("t5_busy_off", busy, 1'b0);
        mem_ack = 1'b1;
        tick(5);
        check("t5_no_tube_write", tube_wr_q.size(), 0);

        // start and stop together: stop wins
        cfg_start = 1'b1; cfg_stop = 1'b1; cfg_addr = 16'h1234;
        tick(1);
        cfg_start = 1'b0; cfg_stop = 1'b0;
        check("t5_start_stop_idle", busy, 1'b0);

        // 6: async reset in the middle of TUBE_RD
        start(16'h0800, 1'b0, 1'b0);
        p_nmi_b = 1'b0;
        wait_tube("t6_tube_seen");
        p_rst_b = 1'b0;
        #1;
        check("t6_tube_cs_b", tube_cs_b, 1'b1);
        check("t6_tube_addr", tube_addr, 3'h0);
        check("t6_cpu_hold", cpu_hold, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_cur_addr", cur_addr, 16'h0000);
        check("t6_mem_req", mem_req, 1'b0);
        p_nmi_b = 1'b1;
        tick(2);
        p_rst_b = 1'b1;
        tick(1);

`ifdef TUBE_R3_DMA_COUNT_EN
        // 7: byte budget of three, then done and further PNMI ignored
        cfg_count = 16'd3;
        start(16'h5000, 1'b0, 1'b0);
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            p_nmi_b = 1'b0;
            wait_tube("t7_tube_seen");
            p_nmi_b = 1'b1;
            tick(8);
        end
        check("t7_done_cycles", done_n, 1);
        check("t7_busy", busy, 1'b0);
        check("t7_cur_addr", cur_addr, 16'h5003);
        p_nmi_b = 1'b0;
        tick(10);
        p_nmi_b = 1'b1;
        check("t7_reads", tube_rd_n, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tube_r3_dma.md
Name: tube_r3_dma

Overview:
- Parasite-side transfer engine directly downstream of the Tube ULA register-3 path.
- Consumes the Tube's PNMI request and moves bytes between Tube register 3 (parasite address 5) and parasite memory, without CPU intervention.
- Owns the parasite bus while a byte moves; the CPU is held via cpu_hold.
- Programmed by the parasite CPU with a start address and direction, then runs until stopped.

Parameters:
- ADDR_W, 16, parasite memory address width
- NMI_HOLDOFF, 3, cycles after each Tube access before the synchronised PNMI is sampled again
- TUBE_R3_ADDR, 3'h5, parasite-side Tube address of register 3 data

Ports:
- p_phi2  in  1  clock; all state on rising edge
- p_rst_b  in  1  async active-low reset
- cfg_start  in  1  one-cycle pulse: latch cfg_addr/cfg_dir/cfg_two_byte and arm
- cfg_stop  in  1  one-cycle pulse: abort and return to IDLE
- cfg_dir  in  1  0 = Tube->memory (host-to-parasite), 1 = memory->Tube
- cfg_two_byte  in  1  1 = move two bytes per PNMI (Tube V flag set)
- cfg_addr  in  ADDR_W  start address
- p_nmi_b  in  1  Tube PNMI, active low, asynchronous to p_phi2
- tube_cs_b  out  1  Tube chip select, active low
- tube_addr  out  3  Tube register address
- tube_rdnw  out  1  1 = read Tube
- tube_din  in  8  Tube read data
- tube_dout  out  8  Tube write data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- mem_ack  in  1  memory completes the request this cycle
- cpu_hold  out  1  stalls parasite CPU while the engine owns the bus
- busy  out  1  armed or transferring
- cur_addr  out  ADDR_W  next memory address

Behaviour:
- Reset values:
  - tube_cs_b=1, tube_rdnw=1.
  - tube_addr=0, tube_dout=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=0, busy=0, cur_addr=0.
  - State is IDLE and the holdoff counter is 0.
- PNMI sync:
  - p_nmi_b passes through a 2-flop synchroniser, which resets to 1 (inactive).
  - nmi_req = synchronised low AND holdoff counter == 0.
- Holdoff counter:
  - Loaded with NMI_HOLDOFF on the cycle of each Tube access.
  - Decrements to 0, saturating.
- States: IDLE, ARMED, TUBE_RD, MEM_WR, MEM_RD, TUBE_WR, NEXT.
- IDLE:
  - busy=0.
  - On cfg_start: cur_addr<=cfg_addr, latch dir and two_byte, byte index=0, go to ARMED.
- ARMED:
  - busy=1, cpu_hold=0.
  - When nmi_req: cpu_hold<=1, go to TUBE_RD if dir=0, else MEM_RD.
- TUBE_RD:
  - Exactly one cycle with tube_cs_b=0, tube_addr=TUBE_R3_ADDR, tube_rdnw=1.
  - tube_din is captured at the end of the cycle into a data register.
  - Go to MEM_WR.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr=cur_addr, mem_wdata=data register.
  - Held until mem_ack; then go to NEXT.
- MEM_RD:
  - mem_req=1, mem_we=0.
  - On mem_ack, capture mem_rdata and go to TUBE_WR.
- TUBE_WR:
  - One cycle with tube_cs_b=0, tube_rdnw=0, tube_dout=data register.
  - Go to NEXT.
- NEXT:
  - cur_addr<=cur_addr+1, wrapping at 2^ADDR_W to 0.
  - If two_byte and byte index==0: byte index<=1 and repeat the same direction immediately, without waiting for PNMI.
  - Otherwise: byte index<=0, cpu_hold<=0, go to ARMED.
- Latency: in ARMED, the first Tube access is 1 cycle after nmi_req is seen high.
- cfg_stop:
  - Accepted in any state; next state is IDLE.
  - Deasserts mem_req, tube_cs_b and cpu_hold the following cycle.
  - A memory access in flight is abandoned; its data is not written to the Tube.
- cfg_start:
  - Ignored when not IDLE.
  - cfg_start and cfg_stop in the same cycle: stop wins.
- mem_ack outside MEM_WR/MEM_RD is ignored.
- PNMI deasserted while already in a transfer: the current byte (or byte pair) completes.
- Asynchronous reset mid-transfer returns all outputs to their reset values immediately.

Optional Feature:
- Macro TUBE_R3_DMA_COUNT_EN.
- When defined, adds ports:
  - cfg_count in 16: bytes to move, latched on cfg_start.
  - done out 1: reset 0.
- When enabled, an internal counter decrements in NEXT. On reaching 0, the engine goes to IDLE and pulses done for exactly one cycle.
- cfg_count=0 at cfg_start means unlimited.
- When not defined: no extra ports; the engine runs until cfg_stop.

Test Plan:
- Reset, then cfg_start with cfg_addr=16'h0400, cfg_dir=0. Drive p_nmi_b low, tube_din=8'hA5, mem_ack=1 -> single tube_cs_b read pulse at addr 5, memory write of A5 to 0400, cur_addr=0401, cpu_hold low again, busy=1.
- cfg_dir=1, cfg_two_byte=1, memory holds 0x11 at 0x2000 and 0x22 at 0x2001, one PNMI -> two Tube writes 11 then 22, cur_addr=2002, no third access while p_nmi_b stays high.
- Hold p_nmi_b low continuously -> consecutive Tube accesses separated by at least NMI_HOLDOFF cycles.
- cfg_addr=16'hFFFF, two single-byte transfers -> writes go to FFFF then 0000.
- Assert cfg_stop while in MEM_RD with mem_ack held low -> next cycle mem_req=0, cpu_hold=0, busy=0; no tube write occurs.
- With TUBE_R3_DMA_COUNT_EN and cfg_count=3: three PNMI-driven bytes, then done pulses for one cycle and a fourth PNMI is ignored. Separately, p_rst_b low mid-TUBE_RD -> all outputs return to reset values immediately.
